ai_move_engine: RTL and testbench

AI_MOVE_ENGINE -- requirements
Module: ai_move_engine

---
 rtl/tictac_pkg.sv | 50 +++++
 rtl/board_eval.sv | 42 ++++
 rtl/ai_move_engine.sv | 142 ++++++++++++++
 tb/tb_ai_move_engine.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tictac_pkg.sv
// Shared board encoding, result codes, score constants and FSM states
// for the tic-tac-toe AI move engine.
package tictac_pkg;

    localparam int CELL_W    = 2;
    localparam int NUM_CELLS = 9;
    localparam int BOARD_W   = CELL_W * NUM_CELLS;

    localparam logic [CELL_W-1:0] CELL_EMPTY = 2'd0;
    localparam logic [CELL_W-1:0] CELL_HUMAN = 2'd1;
    localparam logic [CELL_W-1:0] CELL_AI    = 2'd2;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_P1   = 2'd1,
        RES_P2   = 2'd2,
        RES_DRAW = 2'd3
    } result_e;

    typedef logic signed [2:0] score_t;

    localparam score_t SCORE_NEG2 = -3'sd2;
    localparam score_t SCORE_LOSS = -3'sd1;
    localparam score_t SCORE_DRAW = 3'sd0;
    localparam score_t SCORE_WIN  = 3'sd1;
    localparam score_t SCORE_POS2 = 3'sd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_OUTER,
        ST_INNER,
        ST_FINISH
    } state_e;

    function automatic logic [CELL_W-1:0] cell_at(input logic [BOARD_W-1:0] b,
                                                  input logic [3:0]         idx);
        return b[int'(idx)*CELL_W +: CELL_W];
    endfunction

    function automatic logic [BOARD_W-1:0] place(input logic [BOARD_W-1:0] b,
                                                 input logic [3:0]         idx,
                                                 input logic [CELL_W-1:0]  code);
        logic [BOARD_W-1:0] r;
        r = b;
        r[int'(idx)*CELL_W +: CELL_W] = code;
        return r;
    endfunction

endpackage

// File: rtl/board_eval.sv
// Combinational board evaluator: first completed line (rows, cols, diags)
// wins, otherwise draw when full, otherwise no result.
module board_eval
    import tictac_pkg::*;
(
    input  logic [BOARD_W-1:0] board_i,
    output logic [1:0]         result_o
);

    logic [CELL_W-1:0] c        [NUM_CELLS];
    logic [CELL_W-1:0] line_val [8];
    logic              any_empty;

    always_comb begin
        for (int k = 0; k < NUM_CELLS; k++) begin
            c[k] = board_i[k*CELL_W +: CELL_W];
        end
    end

    // ANDing the codes leaves a nonzero value only when all three cells match.
    assign line_val[0] = c[0] & c[1] & c[2];
    assign line_val[1] = c[3] & c[4] & c[5];
    assign line_val[2] = c[6] & c[7] & c[8];
    assign line_val[3] = c[0] & c[3] & c[6];
    assign line_val[4] = c[1] & c[4] & c[7];
    assign line_val[5] = c[2] & c[5] & c[8];
    assign line_val[6] = c[0] & c[4] & c[8];
    assign line_val[7] = c[6] & c[4] & c[2];

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        any_empty = 1'b0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (c[k] == CELL_EMPTY) any_empty = 1'b1;
        end
        result_o = any_empty ? RES_NONE : RES_DRAW;
        for (int l = 7; l >= 0; l--) begin
            if (line_val[l] != RES_NONE) result_o = line_val[l];
        end
    end

endmodule

// File: rtl/ai_move_engine.sv
// Two-ply minimax move search: each empty cell is tried for the AI and,
// when undecided, scored by the human's best single reply.
module ai_move_engine
    import tictac_pkg::*;
#(
    parameter logic [1:0] HUMAN_CODE = CELL_HUMAN,
    parameter logic [1:0] AI_CODE    = CELL_AI
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BOARD_W-1:0] board_in,
    output logic               busy,
    output logic               done,
    output logic [3:0]         move,
    output logic               no_move
);

    localparam logic [3:0] LAST_CELL = 4'd8;

    state_e             state_q;
    logic [BOARD_W-1:0] board_q;
    logic [3:0]         i_q;
    logic [3:0]         j_q;
    score_t             best_q;
    logic [3:0]         best_move_q;
    score_t             min_q;
    logic               busy_q;
    logic               done_q;
    logic [3:0]         move_q;
    logic               no_move_q;

    logic [BOARD_W-1:0] outer_board;
    logic [BOARD_W-1:0] inner_board;
    logic [BOARD_W-1:0] outer_in;
    logic [1:0]         outer_res;
    logic [1:0]         inner_res;
    logic               outer_empty;
    logic               inner_empty;
    score_t             outer_score;
    score_t             inner_score;
    score_t             min_d;

    assign outer_board = place(board_q, i_q, AI_CODE);
    assign inner_board = place(outer_board, j_q, HUMAN_CODE);
    assign outer_empty = (cell_at(board_q, i_q) == CELL_EMPTY);
    assign inner_empty = (cell_at(outer_board, j_q) == CELL_EMPTY);

    // The outer evaluator doubles as the game-over check on the raw board.
    assign outer_in = (state_q == ST_CHECK) ? board_q : outer_board;

    board_eval u_eval_outer (.board_i(outer_in),    .result_o(outer_res));
    board_eval u_eval_inner (.board_i(inner_board), .result_o(inner_res));

    always_comb begin
        outer_score = (outer_res == AI_CODE) ? SCORE_WIN : SCORE_DRAW;
        inner_score = SCORE_DRAW;
        if (inner_res == HUMAN_CODE)   inner_score = SCORE_LOSS;
        else if (inner_res == AI_CODE) inner_score = SCORE_WIN;
        min_d = min_q;
        if (inner_empty && (inner_score < min_q)) min_d = inner_score;
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            board_q     <= '0;
            i_q         <= '0;
            j_q         <= '0;
            best_q      <= SCORE_NEG2;
            best_move_q <= '0;
            min_q       <= SCORE_POS2;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            move_q      <= '0;
            no_move_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !done_q) begin
                        board_q <= board_in;
                        busy_q  <= 1'b1;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    i_q         <= '0;
                    best_q      <= SCORE_NEG2;
                    best_move_q <= '0;
                    state_q     <= (outer_res != RES_NONE) ? ST_FINISH : ST_OUTER;
                end
                ST_OUTER: begin
                    if (outer_empty && (outer_res == RES_NONE)) begin
                        j_q     <= '0;
                        min_q   <= SCORE_POS2;
                        state_q <= ST_INNER;
                    end else begin
                        if (outer_empty && (outer_score > best_q)) begin
                            best_q      <= outer_score;
                            best_move_q <= i_q;
                        end
                        if (i_q == LAST_CELL) state_q <= ST_FINISH;
                        else                  i_q     <= i_q + 1'b1;
                    end
                end
                ST_INNER: begin
                    min_q <= min_d;
                    if (j_q == LAST_CELL) begin
                        if (min_d > best_q) begin
                            best_q      <= min_d;
                            best_move_q <= i_q;
                        end
                        if (i_q == LAST_CELL) begin
                            state_q <= ST_FINISH;
                        end else begin
                            i_q     <= i_q + 1'b1;
                            state_q <= ST_OUTER;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                ST_FINISH: begin
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    move_q    <= best_move_q;
                    no_move_q <= (best_q == SCORE_NEG2);
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign move    = move_q;
    assign no_move = no_move_q;

endmodule

// File: tb/tb_ai_move_engine.sv
// Directed bench for ai_move_engine: latency, chosen move, game-over,
// reset abort and start-ignore behaviour against hand-computed results.
module tb_ai_move_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [17:0] board_in;
    logic        busy;
    logic        done;
    logic [3:0]  move;
    logic        no_move;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ai_move_engine #(.HUMAN_CODE(2'd1), .AI_CODE(2'd2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .board_in(board_in),
        .busy    (busy),
        .done    (done),
        .move    (move),
        .no_move (no_move)
    );

    // Returns at the negedge just after the edge that samples start.
    task automatic do_start(input logic [17:0] b);
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // lat = edges counted until done is seen (-1 on timeout).
    task automatic wait_done(input int budget, output int lat, output int busy_bad);
        lat      = -1;
        busy_bad = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; board_in = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (move !== 4'd0)    begin errors++; $display("FAIL reset_move got %0d want 0", move); end
        checks++; if (no_move !== 1'b0) begin errors++; $display("FAIL reset_no_move got %0b want 0", no_move); end
        start = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_priority_busy got %0b want 0", busy); end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_empty_board();
        int lat, bb;
        do_start(18'h00000);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy_start got %0b want 1", busy); end
        wait_done(200, lat, bb);
        checks++; if (lat !== 92)       begin errors++; $display("FAIL empty_latency got %0d want 92", lat); end
        checks++; if (bb !== 0)         begin errors++; $display("FAIL empty_busy_window bad_cycles %0d want 0", bb); end
        checks++; if (move !== 4'd0)    begin errors++; $display("FAIL empty_move got %0d want 0", move); end
        checks++; if (no_move !== 1'b0) begin errors++; $display("FAIL empty_no_move got %0b want 0", no_move); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_done_pulse got %0b want 0", done); end
    endtask

    task automatic test_ai_win();
        int lat, bb;
        do_start(18'h0014A);
        wait_done(200, lat, bb);
        checks++; if (lat !== 47)       begin errors++; $display("FAIL win_latency got %0d want 47", lat); end
        checks++; if (move !== 4'd2)    begin errors++; $display("FAIL win_move got %0d want 2", move); end
        checks++; if (no_move !== 1'b0) begin errors++; $display("FAIL win_no_move got %0b want 0", no_move); end
        repeat (3) @(negedge clk);
        checks++; if (move !== 4'd2) begin errors++; $display("FAIL win_move_held got %0d want 2", move); end
    endtask

    task automatic test_block();
        int lat, bb;
        do_start(18'h00205);
        wait_done(200, lat, bb);
        checks++; if (lat !== 65)       begin errors++; $display("FAIL block_latency got %0d want 65", lat); end
        checks++; if (bb !== 0)         begin errors++; $display("FAIL block_busy_window bad_cycles %0d want 0", bb); end
        checks++; if (move !== 4'd2)    begin errors++; $display("FAIL block_move got %0d want 2", move); end
        checks++; if (no_move !== 1'b0) begin errors++; $display("FAIL block_no_move got %0b want 0", no_move); end
    endtask

    task automatic test_draw();
        int lat, bb;
        do_start(18'h16A59);
        wait_done(20, lat, bb);
        checks++; if (lat !== 2)        begin errors++; $display("FAIL draw_latency got %0d want 2", lat); end
        checks++; if (no_move !== 1'b1) begin errors++; $display("FAIL draw_no_move got %0b want 1", no_move); end
        checks++; if (move !== 4'd0)    begin errors++; $display("FAIL draw_move got %0d want 0", move); end
    endtask

    task automatic test_win_beats_block();
        int lat, bb;
        do_start(18'h00A05);
        wait_done(200, lat, bb);
        checks++; if (lat < 0)          begin errors++; $display("FAIL wbb_timeout got %0d want done", lat); end
        checks++; if (move !== 4'd3)    begin errors++; $display("FAIL wbb_move got %0d want 3", move); end
        checks++; if (no_move !== 1'b0) begin errors++; $display("FAIL wbb_no_move got %0b want 0", no_move); end
    endtask

    task automatic test_human_won();
        int lat, bb;
        do_start(18'h00015);
        wait_done(20, lat, bb);
        checks++; if (lat !== 2)        begin errors++; $display("FAIL lost_latency got %0d want 2", lat); end
        checks++; if (no_move !== 1'b1) begin errors++; $display("FAIL lost_no_move got %0b want 1", no_move); end
        checks++; if (move !== 4'd0)    begin errors++; $display("FAIL lost_move got %0d want 0", move); end
    endtask

    task automatic test_reset_mid_search();
        int dones;
        do_start(18'h00000);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
        checks++; if (move !== 4'd0)    begin errors++; $display("FAIL abort_move got %0d want 0", move); end
        checks++; if (no_move !== 1'b0) begin errors++; $display("FAIL abort_no_move got %0b want 0", no_move); end
        dones = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy !== 1'b0) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL abort_activity got %0d want 0", dones); end
    endtask

    task automatic test_back_to_back();
        int lat, bb, extra;
        do_start(18'h00205);
        for (int k = 0; k < 5; k++) begin
            board_in = 18'h0014A ^ 18'(k);
            start    = (k % 2 == 0);
            @(negedge clk);
        end
        start    = 1'b0;
        board_in = 18'h3FFFF;
        wait_done(200, lat, bb);
        if (lat >= 0) lat = lat + 5;
        checks++; if (lat !== 65)       begin errors++; $display("FAIL b2b_latency got %0d want 65", lat); end
        checks++; if (move !== 4'd2)    begin errors++; $display("FAIL b2b_move got %0d want 2", move); end
        checks++; if (no_move !== 1'b0) begin errors++; $display("FAIL b2b_no_move got %0b want 0", no_move); end
        start    = 1'b1;
        board_in = 18'h00000;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_during_done got %0b want 0", busy); end
        extra = 0;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra_done got %0d want 0", extra); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; board_in = '0;
        test_reset();
        test_empty_board();
        test_ai_win();
        test_block();
        test_draw();
        test_human_won();
        test_win_beats_block();
        test_reset_mid_search();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
